// File: rtl/sha256_msg_feeder_if.sv
// Byte-source, compression-core and digest signals of the SHA-256 message feeder.
// The feeder sits on the master side because it drives the core's inputs.
interface sha256_msg_feeder_if;
   logic [7:0]   in_data;
   logic         in_valid;
   logic         in_last;
   logic         in_empty;
   logic         in_ready;
   logic [255:0] blk_H;
   logic [511:0] blk_M;
   logic         blk_valid;
   logic [255:0] core_H;
   logic         core_valid;
   logic [255:0] digest;
   logic         digest_valid;

   modport master (
      input  in_data, in_valid, in_last, in_empty, core_H, core_valid,
      output in_ready, blk_H, blk_M, blk_valid, digest, digest_valid
   );

   modport slave (
      output in_data, in_valid, in_last, in_empty, core_H, core_valid,
      input  in_ready, blk_H, blk_M, blk_valid, digest, digest_valid
   );
endinterface

// File: rtl/sha256_msg_feeder.sv
// Packs a byte stream into padded SHA-256 blocks, hands them to sha256_block and
// chains the returned hash value until the final digest is emitted.
module sha256_msg_feeder #(
   parameter logic [255:0] H_INIT = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19,
   parameter int           LEN_W  = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   sha256_msg_feeder_if.master   bus
);

   typedef enum logic [2:0] {
      S_ABSORB, S_PAD, S_ISSUE, S_WAIT, S_TAIL, S_DIGEST
   } state_t;

   state_t            state_q, state_d;
   logic [6:0]        cnt_q;
   logic [LEN_W-1:0]  bitlen_q;
   logic [255:0]      h_q;
   logic [255:0]      digest_q;
   logic [7:0]        buf_q    [64];
   logic [7:0]        pad_buf  [64];
   logic [7:0]        tail_buf [64];
   logic [511:0]      blk_m;
   logic              pad_pend_q, pad80_q, final_q;
   logic              accept, has_byte;
   logic [63:0]       len64;

   assign len64    = 64'(bitlen_q);
   // An empty beat without in_last is illegal and simply not taken.
   assign accept   = bus.in_valid && (state_q == S_ABSORB) && !(bus.in_empty && !bus.in_last);
   assign has_byte = !(bus.in_last && bus.in_empty);

   always_comb begin
      for (int i = 0; i < 64; i++) begin
         pad_buf[i]  = 8'h00;
         tail_buf[i] = 8'h00;
         if (7'(i) < cnt_q)
            pad_buf[i] = buf_q[i];
         else if (7'(i) == cnt_q)
            pad_buf[i] = 8'h80;
         if (i >= 56) begin
            tail_buf[i] = len64[8*(63-i) +: 8];
            if (cnt_q <= 7'd55)
               pad_buf[i] = len64[8*(63-i) +: 8];
         end
      end
      // The 0x80 marker lands in the tail block only if it did not fit in the data block.
      tail_buf[0] = pad80_q ? 8'h00 : 8'h80;
   end

   always_comb begin
      for (int i = 0; i < 64; i++)
         blk_m[511-8*i -: 8] = buf_q[i];
   end

   assign bus.blk_M        = blk_m;
   assign bus.blk_H        = h_q;
   assign bus.digest       = digest_q;
   assign bus.in_ready     = (state_q == S_ABSORB);
   assign bus.blk_valid    = (state_q == S_ISSUE);
   assign bus.digest_valid = (state_q == S_DIGEST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= S_ABSORB;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_ABSORB: begin
            if (accept) begin
               if (bus.in_last)
                  state_d = S_PAD;
               else if (cnt_q == 7'd63)
                  state_d = S_ISSUE;
            end
         end
         S_PAD:    state_d = S_ISSUE;
         S_ISSUE:  state_d = S_WAIT;
         S_WAIT: begin
            if (bus.core_valid) begin
               if (final_q)
                  state_d = S_DIGEST;
               else if (pad_pend_q)
                  state_d = S_TAIL;
               else
                  state_d = S_ABSORB;
            end
         end
         S_TAIL:   state_d = S_ISSUE;
         S_DIGEST: state_d = S_ABSORB;
         default:  state_d = S_ABSORB;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         bitlen_q   <= '0;
         h_q        <= H_INIT;
         digest_q   <= '0;
         pad_pend_q <= 1'b0;
         pad80_q    <= 1'b0;
         final_q    <= 1'b0;
         for (int i = 0; i < 64; i++)
            buf_q[i] <= 8'h00;
      end else begin
         case (state_q)
            S_ABSORB: begin
               if (accept && has_byte) begin
                  buf_q[cnt_q[5:0]] <= bus.in_data;
                  cnt_q             <= cnt_q + 7'd1;
                  bitlen_q          <= bitlen_q + LEN_W'(8);
               end
            end
            S_PAD: begin
               buf_q <= pad_buf;
               if (cnt_q < 7'd64)
                  pad80_q <= 1'b1;
               if (cnt_q <= 7'd55)
                  final_q <= 1'b1;
               else
                  pad_pend_q <= 1'b1;
            end
            S_WAIT: begin
               if (bus.core_valid) begin
                  h_q <= bus.core_H;
                  if (final_q)
                     digest_q <= bus.core_H;
                  else if (!pad_pend_q)
                     cnt_q <= '0;
               end
            end
            S_TAIL: begin
               buf_q      <= tail_buf;
               pad_pend_q <= 1'b0;
               final_q    <= 1'b1;
            end
            S_DIGEST: begin
               h_q        <= H_INIT;
               bitlen_q   <= '0;
               cnt_q      <= '0;
               pad_pend_q <= 1'b0;
               pad80_q    <= 1'b0;
               final_q    <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_msg_feeder.sv
// Bench for sha256_msg_feeder: drives byte messages, stands in for sha256_block with
// a behavioural compression function, and checks blocks, timing and digests.
module tb_sha256_msg_feeder;

   localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
   localparam string MSG56 = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
   localparam logic [255:0] DIG_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] DIG_56  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   sha256_msg_feeder_if bus();
   sha256_msg_feeder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int acc_cyc, cv_cyc, core_delay, rst_evts, dv_count;
   logic [7:0]   msg_q[$];
   logic [511:0] blk_log[$];
   int           bv_log[$];

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge rst_n) rst_evts++;
   always @(negedge clk) if (bus.digest_valid === 1'b1) dv_count++;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] m);
      logic [31:0] w [64];
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      for (int t = 0; t < 16; t++) w[t] = m[511-32*t -: 32];
      for (int t = 16; t < 64; t++)
         w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
              + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      {a, b, c, d, e, f, g, h} = hin;
      for (int t = 0; t < 64; t++) begin
         t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
         t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
         h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      return {a + hin[255:224], b + hin[223:192], c + hin[191:160], d + hin[159:128],
              e + hin[127:96],  f + hin[95:64],   g + hin[63:32],   h + hin[31:0]};
   endfunction

   // Behavioural sha256_block: answers each blk_valid after core_delay cycles and
   // watches that the feeder holds its request steady meanwhile.
   initial begin
      logic [511:0] cap_m;
      logic [255:0] cap_h;
      int           r0;
      bit           stable;
      bus.core_valid = 1'b0;
      bus.core_H     = '0;
      forever begin
         @(negedge clk);
         bus.core_valid = 1'b0;
         if (bus.blk_valid === 1'b1) begin
            cap_m = bus.blk_M;
            cap_h = bus.blk_H;
            blk_log.push_back(cap_m);
            bv_log.push_back(cyc);
            r0 = rst_evts;
            stable = 1'b1;
            for (int d = 0; d < core_delay; d++) begin
               @(negedge clk);
               if (bus.blk_M !== cap_m || bus.blk_H !== cap_h || bus.in_ready !== 1'b0 ||
                   bus.blk_valid !== 1'b0)
                  stable = 1'b0;
            end
            bus.core_H     = compress(cap_h, cap_m);
            bus.core_valid = 1'b1;
            cv_cyc = cyc;
            if (rst_evts == r0) check("wait_stable", 512'(stable), 512'(1));
         end
      end
   end

   function automatic void load_str(input string s);
      msg_q.delete();
      for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
   endfunction

   task automatic send_msg(input int gap);
      int n = msg_q.size();
      int beats = (n == 0) ? 1 : n;
      int t;
      for (int i = 0; i < beats; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         if (gap > 0) repeat ($urandom_range(0, gap)) @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_data  = (n == 0) ? 8'h00 : msg_q[i];
         bus.in_last  = (i == beats - 1);
         bus.in_empty = (n == 0);
         t = 0;
         while (bus.in_ready !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
         end
         if (t >= 1000) check("in_ready_timeout", 512'(t), 512'(0));
         @(posedge clk);
      end
      @(negedge clk);
      acc_cyc       = cyc;
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.in_empty  = 1'b0;
   endtask

   task automatic wait_digest(input string name, input logic [255:0] exp);
      int t = 0;
      while (bus.digest_valid !== 1'b1 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 2000) begin
         check({name, "_digest_timeout"}, 512'(t), 512'(0));
      end else begin
         check({name, "_digest"}, 512'(bus.digest), 512'(exp));
         check({name, "_digest_latency"}, 512'(cyc - cv_cyc), 512'(1));
      end
      @(negedge clk);
   endtask

   typedef struct {
      string        msg;
      int           nblk;
      logic [511:0] last_blk;
      logic [255:0] dig;
   } vec_t;

   vec_t vecs [4];

   initial begin
      vecs[0] = '{"abc", 1, {32'h61626380, 416'h0, 64'h18}, DIG_ABC};
      vecs[1] = '{"", 1, {8'h80, 504'h0},
                  256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855};
      vecs[2] = '{"a", 1, {16'h6180, 432'h0, 64'h8},
                  256'hca978112ca1bbdcafac231b39a23dc4da786eff8147c4e72b9807785afee48bb};
      vecs[3] = '{MSG56, 2, {448'h0, 64'h1c0}, DIG_56};

      core_delay   = 3;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.in_empty = 1'b0;
      bus.in_data  = 8'h00;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("rst_in_ready",     512'(bus.in_ready),     512'(1));
      check("rst_blk_valid",    512'(bus.blk_valid),    512'(0));
      check("rst_digest_valid", 512'(bus.digest_valid), 512'(0));
      check("rst_blk_H",        512'(bus.blk_H),        512'(IV));
      check("rst_blk_M",        bus.blk_M,              512'(0));
      check("rst_digest",       512'(bus.digest),       512'(0));
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < 4; v++) begin
         load_str(vecs[v].msg);
         blk_log.delete();
         bv_log.delete();
         send_msg(0);
         wait_digest($sformatf("vec%0d", v), vecs[v].dig);
         check($sformatf("vec%0d_nblk", v), 512'(blk_log.size()), 512'(vecs[v].nblk));
         if (blk_log.size() > 0) begin
            check($sformatf("vec%0d_last_blk", v), blk_log[blk_log.size()-1], vecs[v].last_blk);
            check($sformatf("vec%0d_blk_latency", v), 512'(bv_log[0] - acc_cyc), 512'(1));
         end
      end

      // 64 zero bytes: full data block, then a tail block carrying 0x80 and the length.
      msg_q.delete();
      repeat (64) msg_q.push_back(8'h00);
      blk_log.delete();
      bv_log.delete();
      send_msg(0);
      wait_digest("zero64", compress(compress(IV, 512'h0), {8'h80, 440'h0, 64'h200}));
      check("zero64_nblk", 512'(blk_log.size()), 512'(2));
      if (blk_log.size() == 2) begin
         check("zero64_blk0", blk_log[0], 512'h0);
         check("zero64_blk1", blk_log[1], {8'h80, 440'h0, 64'h200});
      end

      // Slow core and a bursty source.
      core_delay = 100;
      load_str(MSG56);
      blk_log.delete();
      bv_log.delete();
      send_msg(3);
      wait_digest("backpressure", DIG_56);
      check("backpressure_nblk", 512'(blk_log.size()), 512'(2));

      // Reset while the core is busy with "abc", then a clean resend.
      core_delay = 10;
      load_str("abc");
      blk_log.delete();
      send_msg(0);
      begin
         int t = 0;
         while (blk_log.size() == 0 && t < 100) begin
            @(negedge clk);
            t++;
         end
         check("rst_mid_blk_seen", 512'(blk_log.size()), 512'(1));
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_mid_in_ready",     512'(bus.in_ready),     512'(1));
      check("rst_mid_blk_valid",    512'(bus.blk_valid),    512'(0));
      check("rst_mid_digest_valid", 512'(bus.digest_valid), 512'(0));
      check("rst_mid_blk_H",        512'(bus.blk_H),        512'(IV));
      check("rst_mid_blk_M",        bus.blk_M,              512'(0));
      check("rst_mid_digest",       512'(bus.digest),       512'(0));
      @(negedge clk);
      rst_n = 1'b1;
      dv_count = 0;
      repeat (15) @(negedge clk);
      check("stale_core_valid_no_digest", 512'(dv_count), 512'(0));
      check("stale_core_valid_in_ready",  512'(bus.in_ready), 512'(1));
      core_delay = 3;
      load_str("abc");
      blk_log.delete();
      send_msg(0);
      wait_digest("resend_abc", DIG_ABC);
      check("resend_abc_nblk", 512'(blk_log.size()), 512'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
